// File: rtl/ram_scan_reader_pkg.sv
// rtl/ram_scan_reader_pkg.sv - shared RAM geometry, clock rate and scan FSM encodings
package ram_scan_reader_pkg;

   localparam int unsigned RAM_ADDR_W = 4;
   localparam int unsigned RAM_DATA_W = 2;
   localparam int unsigned CLK_HZ     = 12_000_000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DWELL   = 2'd3
   } scan_state_e;

   // Counter width able to hold the value 'cycles'; never narrower than one bit.
   function automatic int unsigned dwell_cnt_w(input int unsigned cycles);
      return (cycles < 2) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/ram_scan_reader_dwell.sv
// rtl/ram_scan_reader_dwell.sv - load/count-down dwell timer with an expired flag
module dwell_timer
   import ram_scan_reader_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 3_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = dwell_cnt_w(DWELL_CYCLES);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Counts down to 1 and parks there; the cycle holding 1 is the last dwell cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(DWELL_CYCLES);
      end else if (cnt_q > CNT_W'(1)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ram_scan_reader.sv
// rtl/ram_scan_reader.sv - walks every RAM address, captures each word and holds it for a dwell time
module ram_scan_reader
   import ram_scan_reader_pkg::*;
#(
   parameter int unsigned ADDR_W       = RAM_ADDR_W,
   parameter int unsigned DATA_W       = RAM_DATA_W,
   parameter int unsigned DWELL_CYCLES = 3_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              continuous,
   output logic              r_en,
   output logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

   scan_state_e       state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              r_en_q;
   logic [ADDR_W-1:0] r_addr_q;
   logic [DATA_W-1:0] out_data_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              done_q;
   logic              dwell_load;
   logic              dwell_expired;

   assign dwell_load = (state_q == ST_CAPTURE);

   dwell_timer #(
      .DWELL_CYCLES (DWELL_CYCLES)
   ) u_dwell (
      .clk       (clk),
      .rst       (rst),
      .load_i    (dwell_load),
      .expired_o (dwell_expired)
   );

   // Outputs are registered alongside the state so r_en/r_addr are glitch-free toward the RAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         r_en_q      <= 1'b0;
         r_addr_q    <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         r_en_q      <= 1'b0;
         r_addr_q    <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // A start coinciding with the closing done pulse is dropped, not queued.
               if (start && !done_q) begin
                  state_q  <= ST_ISSUE;
                  addr_q   <= '0;
                  r_en_q   <= 1'b1;
                  r_addr_q <= '0;
                  busy_q   <= 1'b1;
               end
            end
            ST_ISSUE: begin
               state_q <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               out_data_q  <= r_data;
               out_addr_q  <= addr_q;
               out_valid_q <= 1'b1;
               state_q     <= ST_DWELL;
            end
            ST_DWELL: begin
               if (dwell_expired) begin
                  if (addr_q != ADDR_MAX) begin
                     addr_q   <= addr_q + ADDR_W'(1);
                     r_addr_q <= addr_q + ADDR_W'(1);
                     r_en_q   <= 1'b1;
                     state_q  <= ST_ISSUE;
                  end else begin
                     done_q <= 1'b1;
                     if (continuous) begin
                        addr_q   <= '0;
                        r_addr_q <= '0;
                        r_en_q   <= 1'b1;
                        state_q  <= ST_ISSUE;
                     end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                     end
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign r_en      = r_en_q;
   assign r_addr    = r_addr_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
